// File: rtl/router_input_unit.sv
// Virtual-channel input unit for one router port: per-VC FIFOs, per-VC packet FSM
// with XY routing on head flits, switch-allocator request/grant handshake and credit return.
module router_input_unit #(
    parameter int X_SIZE     = 4,
    parameter int Y_SIZE     = 4,
    parameter int FLIT_WIDTH = 80,
    parameter int NUM_VC     = 4,
    parameter int VC_DEPTH   = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [$clog2(X_SIZE)-1:0]                       id_x,
    input  logic [$clog2(Y_SIZE)-1:0]                       id_y,
    input  logic                                            in_valid,
    input  logic [FLIT_WIDTH-1:0]                           in_flit,
    input  logic [NUM_VC-1:0]                               vc_grant,
    output logic [NUM_VC-1:0]                               vc_req,
    output logic [3*NUM_VC-1:0]                             vc_route,
    output logic [FLIT_WIDTH*NUM_VC-1:0]                    vc_flit,
    output logic                                            credit_valid,
    output logic [((NUM_VC > 1) ? $clog2(NUM_VC) : 1)-1:0]  credit_vc,
    output logic                                            err
);

    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(VC_DEPTH);
    localparam logic [4:0]       NUM_VC_5 = 5'(NUM_VC);

    typedef enum logic [1:0] {IDLE, ROUTING, ACTIVE} vc_state_t;

    logic [4:0]        in_vcx;
    logic              in_vcx_ok;
    logic [1:0]        id_x2;
    logic [1:0]        id_y2;
    logic [NUM_VC-1:0] req_vec;
    logic [NUM_VC-1:0] full_vec;
    logic [NUM_VC-1:0] discard_cand;
    logic [NUM_VC-1:0] pop_vec;
    logic [NUM_VC-1:0] push_vec;
    logic [NUM_VC-1:0] drop_vec;
    logic [VC_W-1:0]   pop_idx;
    logic              pop_any;
    logic              discard_pop;
    logic              multi_grant;

    assign in_vcx      = in_flit[15:11];
    assign in_vcx_ok   = (in_vcx < NUM_VC_5);
    assign id_x2       = 2'(id_x);
    assign id_y2       = 2'(id_y);
    assign multi_grant = |(vc_grant & (vc_grant - NUM_VC'(1)));
    assign vc_req      = req_vec;

    // One pop per cycle (single credit port): lowest requesting grant first, then lowest stray discard.
    always_comb begin
        pop_vec     = '0;
        pop_idx     = '0;
        pop_any     = 1'b0;
        discard_pop = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (!pop_any && vc_grant[v] && req_vec[v]) begin
                pop_vec[v] = 1'b1;
                pop_idx    = VC_W'(v);
                pop_any    = 1'b1;
            end
        end
        for (int v = 0; v < NUM_VC; v++) begin
            if (!pop_any && discard_cand[v]) begin
                pop_vec[v]  = 1'b1;
                pop_idx     = VC_W'(v);
                pop_any     = 1'b1;
                discard_pop = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        logic [FLIT_WIDTH-1:0] mem [VC_DEPTH];
        logic [PTR_W-1:0]      rd_ptr_reg;
        logic [PTR_W-1:0]      wr_ptr_reg;
        logic [CNT_W-1:0]      count_reg;
        vc_state_t             state_reg;
        logic [2:0]            route_reg;
        logic [FLIT_WIDTH-1:0] front;
        logic [1:0]            front_type;
        logic [1:0]            dst_x;
        logic [1:0]            dst_y;
        logic [2:0]            route_calc;
        logic                  empty;
        logic                  hit;

        assign front      = mem[rd_ptr_reg];
        assign front_type = front[1:0];
        assign dst_x      = front[8:7];
        assign dst_y      = front[10:9];
        assign empty      = (count_reg == '0);
        assign hit        = in_valid && in_vcx_ok && (in_vcx == 5'(gi));

        assign full_vec[gi]     = (count_reg == FULL_CNT);
        assign push_vec[gi]     = hit && (!full_vec[gi] || pop_vec[gi]);
        assign drop_vec[gi]     = hit && full_vec[gi] && !pop_vec[gi];
        assign req_vec[gi]      = (state_reg == ACTIVE) && !empty;
        // Body or tail at the front of an idle VC has no head to belong to.
        assign discard_cand[gi] = (state_reg == IDLE) && !empty && (front_type[1] ^ front_type[0]);

        always_comb begin
            if (dst_x > id_x2)      route_calc = 3'd0;
            else if (dst_x < id_x2) route_calc = 3'd1;
            else if (dst_y > id_y2) route_calc = 3'd3;
            else if (dst_y < id_y2) route_calc = 3'd2;
            else                    route_calc = 3'd4;
        end

        always_ff @(posedge clk) begin
            if (push_vec[gi]) mem[wr_ptr_reg] <= in_flit;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
                state_reg  <= IDLE;
                route_reg  <= '0;
            end else begin
                if (push_vec[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop_vec[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                count_reg <= count_reg + CNT_W'(push_vec[gi]) - CNT_W'(pop_vec[gi]);
                case (state_reg)
                    IDLE:    if (!empty && (front_type[1] == front_type[0])) state_reg <= ROUTING;
                    ROUTING: begin
                        route_reg <= route_calc;
                        state_reg <= ACTIVE;
                    end
                    ACTIVE:  if (pop_vec[gi] && front_type[1]) state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end

        assign vc_route[3*gi +: 3]                    = route_reg;
        assign vc_flit[FLIT_WIDTH*gi +: FLIT_WIDTH] = empty ? '0 : front;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_valid <= 1'b0;
            credit_vc    <= '0;
            err          <= 1'b0;
        end else begin
            credit_valid <= pop_any;
            if (pop_any) credit_vc <= pop_idx;
            if (discard_pop || multi_grant || (|drop_vec) || (in_valid && !in_vcx_ok))
                err <= 1'b1;
        end
    end

endmodule
